nibble_serial_subtractor: RTL



---
 rtl/nibble_serial_subtractor_if.sv | 25 ++
 rtl/nibble_serial_subtractor.sv | 100 ++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor_if.sv
// Handshake and operand/result bundle for nibble_serial_subtractor.
// The slave modport is the subtractor side.
interface nibble_serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf, zero
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Serial A - B, one NIB-bit slice per clock through a registered borrow chain.
// Results and flags are registered and change only on entry to DONE.
module nibble_serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NIB   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  nibble_serial_subtractor_if.slave bus
);
  localparam int unsigned NSL  = WIDTH / NIB;
  localparam int unsigned IW   = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_work, r_diff;
  logic [IW-1:0]    r_idx;
  logic             r_carry, r_borrow, r_ovf, r_zero;

  logic             w_accept, w_last;
  logic [NIB-1:0]   w_a_sl, w_b_sl;
  logic [NIB:0]     w_s;
  logic [WIDTH-1:0] w_work_next;

  assign w_last = (r_idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next   = S_IDLE;
        end
      end
      S_RUN:   if (w_last) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Slice i: a + ~b + carry, carry seeded with 1 for the two's-complement +1
  always_comb begin
    w_a_sl      = r_a[r_idx*NIB +: NIB];
    w_b_sl      = r_b[r_idx*NIB +: NIB];
    w_s         = {1'b0, w_a_sl} + {1'b0, ~w_b_sl} + {{NIB{1'b0}}, r_carry};
    w_work_next = r_work;
    w_work_next[r_idx*NIB +: NIB] = w_s[NIB-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_work  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b1;
    end else if (r_state == S_RUN) begin
      r_work  <= w_work_next;
      r_carry <= w_s[NIB];
      if (w_last) begin
        // Final slice: publish the completed word straight into the held outputs
        r_idx    <= '0;
        r_diff   <= w_work_next;
        r_borrow <= ~w_s[NIB];
        r_ovf    <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                    (w_work_next[WIDTH-1] != r_a[WIDTH-1]);
        r_zero   <= (w_work_next == '0);
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign bus.busy   = (r_state == S_RUN);
  assign bus.done   = (r_state == S_DONE);
  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;
  assign bus.ovf    = r_ovf;
  assign bus.zero   = r_zero;
endmodule
